// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: drives the PLL reset, qualifies lock, and releases
// the design reset once lock has been stable; retries, detects loss, reports failure.
module pll_reset_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRIES  = 3,
  parameter int CNT_W        = 20
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       lock_lost,
  output logic [3:0] retries,
  output logic       fail
);

  localparam int SYNC_STAGES = 2;
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]       MAX_R     = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t                 state, state_nx;
  logic [CNT_W-1:0]       cnt, cnt_nx;
  logic [3:0]             retries_nx;
  logic                   lock_lost_nx;
  logic [SYNC_STAGES-1:0] lock_pipe;
  logic                   locked_s;

  // locked comes straight from the PLL analog side; two flops before use
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) lock_pipe <= '0;
    else     lock_pipe <= {lock_pipe[SYNC_STAGES-2:0], locked};
  end

  assign locked_s = lock_pipe[SYNC_STAGES-1];

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    retries_nx   = retries;
    lock_lost_nx = 1'b0;
    if (relock_req) begin
      // restart wins over everything, including a simultaneous lock loss
      state_nx   = S_RESET_PLL;
      cnt_nx     = '0;
      retries_nx = '0;
    end else begin
      unique case (state)
        S_RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state_nx = S_WAIT_LOCK;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_nx = S_STABILIZE;
            cnt_nx   = '0;
          end else if (cnt == TO_LAST) begin
            cnt_nx = '0;
            if (retries == MAX_R) begin
              state_nx = S_FAIL;
            end else begin
              state_nx   = S_RESET_PLL;
              retries_nx = retries + 4'd1;
            end
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        S_STABILIZE: begin
          // a glitch restarts the wait but is not charged as a retry
          if (!locked_s) begin
            state_nx = S_WAIT_LOCK;
            cnt_nx   = '0;
          end else if (cnt == STAB_LAST) begin
            state_nx = S_RUN;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            state_nx     = S_RESET_PLL;
            cnt_nx       = '0;
            retries_nx   = '0;
            lock_lost_nx = 1'b1;
          end
        end
        S_FAIL: begin
          cnt_nx = '0;
        end
        default: begin
          state_nx   = S_RESET_PLL;
          cnt_nx     = '0;
          retries_nx = '0;
        end
      endcase
    end
  end

  // outputs are decoded from the next state so they move on the state edge
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= S_RESET_PLL;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
      retries   <= '0;
      fail      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pll_rst   <= (state_nx == S_RESET_PLL) || (state_nx == S_FAIL);
      sys_rst   <= (state_nx != S_RUN);
      ready     <= (state_nx == S_RUN);
      lock_lost <= lock_lost_nx;
      retries   <= retries_nx;
      fail      <= (state_nx == S_FAIL);
    end
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Controls the board clock PLL: drives its reset, watches its lock output, and releases the design reset only once lock is stable.
- Runs on the PLL reference clock.
- Retries a PLL that fails to lock, detects lock loss during operation, and reports a permanent failure.
- Sits between the PLL wrapper and all downstream reset synchronizers. Each output clock domain re-synchronizes `sys_rst` locally.

Parameters:
- RST_CYCLES, 16: cycles `pll_rst` is held high per PLL reset attempt (≥1).
- LOCK_STABLE, 1024: consecutive synchronized-lock cycles required before release (≥1).
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before a retry (≥2).
- MAX_RETRIES, 3: retries after the initial attempt before FAIL (0..15).
- CNT_W, 20: shared counter width; every count parameter is ≤ 2^CNT_W.

Ports:
- refclk  in  1  reference clock, sole clock.
- rst  in  1  asynchronous, active-high reset.
- locked  in  1  PLL lock, asynchronous to refclk.
- relock_req  in  1  synchronous request to restart the PLL.
- pll_rst  out  1  PLL reset.
- sys_rst  out  1  design reset, active high.
- ready  out  1  high only in RUN.
- lock_lost  out  1  one-cycle pulse on lock loss in RUN.
- retries  out  4  retries used in the current bring-up.
- fail  out  1  high in FAIL.

Behaviour:
- **Lock synchronizer:** `locked` passes through a 2-flop synchronizer, reset to 0. Its output is `locked_s`.
- **Output timing:** all outputs are registered and updated on the same edge as the state register.
- **Reset values (while rst high):**
  - state RESET_PLL, counter 0;
  - `pll_rst`=1, `sys_rst`=1;
  - `ready`=0, `lock_lost`=0, `fail`=0, `retries`=0.
- **RESET_PLL:** `pll_rst`=1, `sys_rst`=1. Counter counts 0..RST_CYCLES-1, then go to WAIT_LOCK with counter cleared.
- **WAIT_LOCK:** `pll_rst`=0.
  - If `locked_s`=1: go to STABILIZE, counter cleared.
  - Else the counter increments. On the cycle it equals LOCK_TIMEOUT-1:
    - if `retries`==MAX_RETRIES, go to FAIL;
    - else `retries`+1 and go to RESET_PLL.
- **STABILIZE:** `pll_rst`=0, `sys_rst`=1.
  - If `locked_s`=0: go to WAIT_LOCK, counter cleared (timeout restarts, `retries` unchanged).
  - Else when the counter equals LOCK_STABLE-1, go to RUN.
- **RUN:** `sys_rst`=0, `ready`=1.
  - If `locked_s`=0: go to RESET_PLL, `retries` cleared, `lock_lost`=1 for exactly one cycle.
- **FAIL:** `pll_rst`=1, `sys_rst`=1, `fail`=1. Left only by `rst` or `relock_req`.
- **relock_req:** in any state, go to RESET_PLL next edge with counter and `retries` cleared. It has priority over all other transitions.
  - `lock_lost` is not pulsed when the exit is caused by `relock_req`, even if lock was lost in the same cycle.
- **Release latency:** with `locked` high before `rst` falls, `sys_rst` falls on edge RST_CYCLES+1+LOCK_STABLE after release: RST_CYCLES in RESET_PLL, 1 in WAIT_LOCK, LOCK_STABLE in STABILIZE.
- **Lock-loss latency:** `sys_rst` rises 3 edges after `locked` falls in RUN (2 synchronizer stages plus the state edge).
- **Total attempts:** MAX_RETRIES+1. Time from rst release to `fail` with `locked`=0 is (MAX_RETRIES+1)×(RST_CYCLES+LOCK_TIMEOUT) edges.
- **rst mid-operation:** asserting `rst` in any state immediately forces the reset values asynchronously.

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, MAX_RETRIES=2.
1. **Normal bring-up:** `locked`=1 throughout, release `rst` → `pll_rst` high for edges 1–4, `sys_rst` and `ready` change on edge 13, `retries`=0, `fail`=0.
2. **Timeout to FAIL:** `locked`=0 throughout → three `pll_rst` pulses of 4 cycles each, 32 cycles apart; `retries` steps 1 then 2; `fail`=1 at edge 108 with `pll_rst` and `sys_rst` high.
3. **Lock glitch in STABILIZE:** drop `locked` for 3 cycles mid-STABILIZE → state returns to WAIT_LOCK; `sys_rst` stays 1 until a full 8-cycle STABILIZE completes; `retries` unchanged.
4. **Lock loss in RUN:** drop `locked` in RUN → on the 3rd edge `sys_rst`=1, `ready`=0, `pll_rst`=1, `lock_lost` high for one cycle; with lock restored, RUN is re-entered 4+1+8 edges later.
5. **Recovery from FAIL:** pulse `relock_req` in FAIL with `locked`=1 → `fail`=0 and `retries`=0 next edge; normal bring-up timing as in scenario 1. Same-cycle `relock_req` and lock loss in RUN → single transition, `lock_lost` stays 0.
6. **Async reset mid-run:** assert `rst` between edges mid-STABILIZE → all outputs take reset values before the next edge; release → scenario 1 timing.
